// File: rtl/vj_face_collector.sv
//------------------------------------------------------------------------------
// vj_face_collector: buffers vj_pipeline detections in a FWFT FIFO, streams them
// out over valid/ready, and tracks per-frame counts. Option: VJ_DEDUP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vj_face_collector #(
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int DEDUP_DIST = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   face_valid,
  input  logic [1:0][31:0]       face_top_left,
  input  logic [3:0]             face_pyramid,
  input  logic                   frame_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0][31:0]       out_top_left,
  output logic [3:0]             out_pyramid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       face_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic                   done
);

  localparam int c_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vj_face_collector: DEPTH must be a power of 2 and >= 2");
  end
  if (DEDUP_DIST < 0 || CNT_W < 1) begin : g_bad_param
    $error("vj_face_collector: DEDUP_DIST must be >= 0 and CNT_W >= 1");
  end

  state_t           r_state;
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic [CNT_W-1:0] r_face;
  logic [CNT_W-1:0] r_drop;
  logic             r_ovf;
  logic [1:0][31:0] r_mem_tl  [DEPTH];
  logic [3:0]       r_mem_pyr [DEPTH];

  logic          w_pop, w_full, w_dup, w_cand, w_push, w_drop, w_drop_full;
  logic [c_AW:0] w_count_next;

`ifdef VJ_DEDUP_EN
  logic             r_last_vld;
  logic [1:0][31:0] r_last_tl;
  logic [3:0]       r_last_pyr;

  function automatic logic [31:0] f_absdiff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_dup = r_last_vld && (face_pyramid == r_last_pyr) &&
                 (f_absdiff(face_top_left[0], r_last_tl[0]) <= 32'(DEDUP_DIST)) &&
                 (f_absdiff(face_top_left[1], r_last_tl[1]) <= 32'(DEDUP_DIST));

  // Only detections that actually enter the FIFO become the dedup reference.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_vld <= 1'b0;
      r_last_tl  <= '0;
      r_last_pyr <= '0;
    end else if (clear) begin
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last_vld <= 1'b1;
      r_last_tl  <= face_top_left;
      r_last_pyr <= face_pyramid;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_pop        = ~clear & out_valid & out_ready;
  assign w_full       = (r_count == (c_AW+1)'(DEPTH));
  assign w_cand       = ~clear & face_valid & (r_state != S_DONE) & ~w_dup;
  assign w_push       = w_cand & (~w_full | w_pop);
  assign w_drop_full  = w_cand & w_full & ~w_pop;
  assign w_drop       = ~clear & face_valid & ~w_push;
  assign w_count_next = r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_tl[r_wr_ptr]  <= face_top_left;
      r_mem_pyr[r_wr_ptr] <= face_pyramid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_COLLECT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_face   <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_state  <= S_COLLECT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_face   <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      if (w_push && (r_face != '1)) r_face <= r_face + 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_drop_full) r_ovf <= 1'b1;
      // Completion looks at next-cycle occupancy so a final same-cycle pop counts.
      case (r_state)
        S_COLLECT: if (frame_done) r_state <= (w_count_next == '0) ? S_DONE : S_DRAIN;
        S_DRAIN:   if (w_count_next == '0) r_state <= S_DONE;
        S_DONE:    r_state <= S_DONE;
        default:   r_state <= S_COLLECT;
      endcase
    end
  end

  assign out_valid    = (r_count != '0);
  assign out_top_left = out_valid ? r_mem_tl[r_rd_ptr]  : '0;
  assign out_pyramid  = out_valid ? r_mem_pyr[r_rd_ptr] : '0;
  assign fifo_count   = r_count;
  assign face_count   = r_face;
  assign drop_count   = r_drop;
  assign overflow     = r_ovf;
  assign done         = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_vj_face_collector.sv
//------------------------------------------------------------------------------
// tb_vj_face_collector: directed bench with a queue-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vj_face_collector;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int DIST  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             face_valid = 1'b0;
  logic [1:0][31:0] face_top_left = '0;
  logic [3:0]       face_pyramid = '0;
  logic             frame_done = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [1:0][31:0] out_top_left;
  logic [3:0]       out_pyramid;
  logic [4:0]       fifo_count;
  logic [CNT_W-1:0] face_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  vj_face_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DEDUP_DIST(DIST)) dut (
    .clock(clock), .reset(reset), .clear(clear), .face_valid(face_valid),
    .face_top_left(face_top_left), .face_pyramid(face_pyramid),
    .frame_done(frame_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_top_left(out_top_left), .out_pyramid(out_pyramid),
    .fifo_count(fifo_count), .face_count(face_count), .drop_count(drop_count),
    .overflow(overflow), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic [3:0]  pyr;
  } ent_t;

  // Reference model: queue plus frame bookkeeping.
  ent_t        m_q[$];
  int unsigned m_face = 0, m_drop = 0;
  bit          m_ovf = 0, m_seen_fd = 0, m_done = 0;
  bit          m_last_vld = 0;
  ent_t        m_last;

  function automatic longint absd(longint a, longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_face = 0; m_drop = 0; m_ovf = 0;
    m_seen_fd = 0; m_done = 0; m_last_vld = 0;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_clear();
    end else if (clear) begin
      model_clear();
    end else begin
      bit   dup, pop;
      ent_t e;
      e   = '{row: face_top_left[0], col: face_top_left[1], pyr: face_pyramid};
      dup = 0;
`ifdef VJ_DEDUP_EN
      dup = m_last_vld && (e.pyr == m_last.pyr) &&
            absd(e.row, m_last.row) <= DIST && absd(e.col, m_last.col) <= DIST;
`endif
      pop = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (face_valid) begin
        if (m_done || dup) begin
          if (m_drop < 65535) m_drop++;
        end else if (m_q.size() < DEPTH) begin
          m_q.push_back(e);
          if (m_face < 65535) m_face++;
          m_last = e; m_last_vld = 1;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
      if (frame_done) m_seen_fd = 1;
      if (m_seen_fd && m_q.size() == 0) m_done = 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("m_valid", 64'(out_valid), 64'(m_q.size() > 0));
      chk("m_count", 64'(fifo_count), 64'(m_q.size()));
      chk("m_face", 64'(face_count), 64'(m_face));
      chk("m_drop", 64'(drop_count), 64'(m_drop));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
      chk("m_done", 64'(done), 64'(m_done));
      if (m_q.size() > 0) begin
        chk("m_row", 64'(out_top_left[0]), 64'(m_q[0].row));
        chk("m_col", 64'(out_top_left[1]), 64'(m_q[0].col));
        chk("m_pyr", 64'(out_pyramid), 64'(m_q[0].pyr));
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input int row, input int col, input int pyr);
    face_valid = 1'b1;
    face_top_left[0] = 32'(row);
    face_top_left[1] = 32'(col);
    face_pyramid = 4'(pyr);
    cyc();
    face_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and first-word latency
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(fifo_count), 0);
    chk("rst_tl", 64'(out_top_left), 0);
    chk("rst_done", 64'(done), 0);
    push(5, 7, 2);
    chk("t1_valid", 64'(out_valid), 1);
    chk("t1_row", 64'(out_top_left[0]), 5);
    chk("t1_col", 64'(out_top_left[1]), 7);
    chk("t1_pyr", 64'(out_pyramid), 2);
    chk("t1_count", 64'(fifo_count), 1);
    chk("t1_face", 64'(face_count), 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t1_empty", 64'(out_valid), 0);

    // 2: overflow on the 17th push, then drain in order
    do_clear();
    for (int i = 0; i < 17; i++) push(100 + i, 200 + i, i % 16);
    chk("t2_count", 64'(fifo_count), 16);
    chk("t2_ovf", 64'(overflow), 1);
    chk("t2_drop", 64'(drop_count), 1);
    chk("t2_face", 64'(face_count), 16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 64'(out_top_left[0]), 64'(100 + i));
      cyc();
    end
    out_ready = 1'b0;
    chk("t2_drained", 64'(fifo_count), 0);

    // 3: full FIFO with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 16; i++) push(1000 + i, 50, 3);
    out_ready = 1'b1;
    push(300, 300, 4);
    out_ready = 1'b0;
    chk("t3_count", 64'(fifo_count), 16);
    chk("t3_ovf", 64'(overflow), 0);
    chk("t3_face", 64'(face_count), 17);
    chk("t3_head", 64'(out_top_left[0]), 1001);

    // 4: frame completion after drain, drop in DONE, clear
    do_clear();
    for (int i = 0; i < 3; i++) push(20 + i, 30 + i, 1);
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    chk("t4_notdone", 64'(done), 0);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("t4_notyet", 64'(done), 0);
    cyc();
    chk("t4_done", 64'(done), 1);
    chk("t4_empty", 64'(fifo_count), 0);
    out_ready = 1'b0;
    push(40, 40, 1);
    chk("t4_drop", 64'(drop_count), 1);
    chk("t4_nopush", 64'(fifo_count), 0);
    chk("t4_ovf", 64'(overflow), 0);
    do_clear();
    chk("t4_clr_done", 64'(done), 0);
    chk("t4_clr_face", 64'(face_count), 0);
    chk("t4_clr_drop", 64'(drop_count), 0);

    // 4b: frame_done on an empty FIFO goes straight to done
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    chk("t4b_done", 64'(done), 1);
    do_clear();

    // 5: duplicate suppression sequence
    push(10, 10, 1);
    push(11, 12, 1);
    push(10, 10, 2);
    push(13, 10, 1);
`ifdef VJ_DEDUP_EN
    chk("t5_face", 64'(face_count), 3);
    chk("t5_drop", 64'(drop_count), 1);
`else
    chk("t5_face", 64'(face_count), 4);
    chk("t5_drop", 64'(drop_count), 0);
`endif

    // 6: asynchronous reset mid-cycle with entries queued
    do_clear();
    for (int i = 0; i < 5; i++) push(60 + i, 70, 5);
    chk("t6_count", 64'(fifo_count), 5);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 0);
    chk("t6_cnt0", 64'(fifo_count), 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_after", 64'(fifo_count), 0);
    chk("t6_face", 64'(face_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
